// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI responder.
package spi_pkg;

  localparam int SHIFT_REG_WIDTH = 8;

  // SPI modes as {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Three-flop synchroniser for an asynchronous pin with single-clk rise/fall pulses.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_ff;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff <= {3{RESET_VAL}};
    end else begin
      sync_ff <= {sync_ff[1:0], din};
    end
  end

  // flop 2 is the first metastability-safe stage; flop 3 is its one-clk history
  assign rise = sync_ff[1] & ~sync_ff[2];
  assign fall = ~sync_ff[1] & sync_ff[2];

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversampled SCLK/CS/MOSI, one-entry Tx holding register, pulsed Rx byte.
// state  | meaning
// IDLE   | CS high, waiting for the synchronised CS falling edge
// ACTIVE | CS low, shifting bytes on sample/shift edges
module spi_slave #(
  parameter logic CPOL = 1'b0,
  parameter logic CPHA = 1'b0,
  parameter int SHIFT_REG_WIDTH = spi_pkg::SHIFT_REG_WIDTH,
  parameter logic [SHIFT_REG_WIDTH-1:0] DEFAULT_TX = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SHIFT_REG_WIDTH-1:0] i_Tx_Byte,
  input  logic                       i_Tx_Valid,
  output logic                       o_Tx_Ready,
  output logic [SHIFT_REG_WIDTH-1:0] o_Rx_Byte,
  output logic                       o_Rx_Valid,
  output logic                       o_Tx_Underrun,
  input  logic                       i_SPI_Clk,
  input  logic                       i_SPI_CSLow,
  input  logic                       i_SPI_Mosi,
  output logic                       o_SPI_Miso,
  output logic                       o_SPI_MisoEn
);
  import spi_pkg::*;

  localparam int W = SHIFT_REG_WIDTH;
  localparam int CNT_W = (W > 2) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

  state_t           state;
  logic [W-1:0]     tx_shift;
  logic [W-1:0]     rx_shift;
  logic [W-1:0]     hold_reg;
  logic             hold_full;
  logic [CNT_W-1:0] bit_cnt;
  logic             reload_pending;
  logic [1:0]       mosi_ff;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic leading, trailing, sample_edge, shift_edge;
  logic tx_accept, load_now;
  logic mosi_s;
  logic [W-1:0] load_val, rx_next;

  spi_sync_edge #(.RESET_VAL(CPOL)) u_sclk_sync (
    .clk  (clk),
    .reset(reset),
    .din  (i_SPI_Clk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .reset(reset),
    .din  (i_SPI_CSLow),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mosi_ff <= '0;
    end else begin
      mosi_ff <= {mosi_ff[0], i_SPI_Mosi};
    end
  end

  assign mosi_s      = mosi_ff[1];
  assign leading     = CPOL ? sclk_fall : sclk_rise;
  assign trailing    = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trailing : leading;
  assign shift_edge  = CPHA ? leading : trailing;
  assign tx_accept   = i_Tx_Valid && o_Tx_Ready;
  assign load_val    = hold_full ? hold_reg : DEFAULT_TX;
  assign rx_next     = {rx_shift[W-2:0], mosi_s};
  // a reload after a wrap waits for the shift edge so CS-high edges never load
  assign load_now    = (state == IDLE) ? cs_fall
                                       : (!cs_rise && shift_edge && reload_pending);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      tx_shift       <= '0;
      rx_shift       <= '0;
      hold_reg       <= '0;
      hold_full      <= 1'b0;
      bit_cnt        <= '0;
      reload_pending <= 1'b0;
      o_Tx_Ready     <= 1'b1;
      o_Rx_Byte      <= '0;
      o_Rx_Valid     <= 1'b0;
      o_Tx_Underrun  <= 1'b0;
      o_SPI_Miso     <= 1'b0;
      o_SPI_MisoEn   <= 1'b0;
    end else begin
      o_Rx_Valid    <= 1'b0;
      o_Tx_Underrun <= 1'b0;

      if (load_now) begin
        o_Tx_Underrun <= !hold_full;
        hold_full     <= tx_accept;
        o_Tx_Ready    <= !tx_accept;
        if (tx_accept) hold_reg <= i_Tx_Byte;
      end else if (tx_accept) begin
        hold_full  <= 1'b1;
        hold_reg   <= i_Tx_Byte;
        o_Tx_Ready <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state          <= ACTIVE;
            o_SPI_MisoEn   <= 1'b1;
            bit_cnt        <= '0;
            reload_pending <= 1'b0;
            // tx_shift[W-1] is always the next bit to put on MISO
            if (CPHA) begin
              tx_shift <= load_val;
            end else begin
              tx_shift   <= load_val << 1;
              o_SPI_Miso <= load_val[W-1];
            end
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state          <= IDLE;
            o_SPI_MisoEn   <= 1'b0;
            bit_cnt        <= '0;
            reload_pending <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_shift <= rx_next;
              if (bit_cnt == LAST_BIT) begin
                bit_cnt        <= '0;
                o_Rx_Byte      <= rx_next;
                o_Rx_Valid     <= 1'b1;
                reload_pending <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            if (shift_edge) begin
              if (reload_pending) begin
                reload_pending <= 1'b0;
                tx_shift       <= load_val << 1;
                o_SPI_Miso     <= load_val[W-1];
              end else begin
                tx_shift   <= tx_shift << 1;
                o_SPI_Miso <= tx_shift[W-1];
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: one instance per SPI mode, a bit-banged master and Rx/MISO monitors.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_byte;
  logic [3:0] tx_valid;
  logic [3:0] tx_ready;
  logic [7:0] rx_byte [4];
  logic [3:0] rx_valid;
  logic [3:0] underrun;
  logic [3:0] sclk;
  logic [3:0] cs_b;
  logic       mosi;
  logic [3:0] miso;
  logic [3:0] misoen;

  logic [1:0] sel = 2'd0;
  logic       cur_miso;
  int         checks = 0;
  int         failures = 0;
  int         rx_pulses = 0;
  int         ur_pulses = 0;
  time        last_ok_time = 0;
  bit         mon_en = 1'b0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];

  always #5 clk = ~clk;

  genvar g;
  for (g = 0; g < 4; g++) begin : g_dut
    localparam logic [1:0] MV = 2'(g);
    spi_slave #(
      .CPOL(MV[1]), .CPHA(MV[0]), .SHIFT_REG_WIDTH(8), .DEFAULT_TX(8'hFF)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .i_Tx_Byte    (tx_byte),
      .i_Tx_Valid   (tx_valid[g]),
      .o_Tx_Ready   (tx_ready[g]),
      .o_Rx_Byte    (rx_byte[g]),
      .o_Rx_Valid   (rx_valid[g]),
      .o_Tx_Underrun(underrun[g]),
      .i_SPI_Clk    (sclk[g]),
      .i_SPI_CSLow  (cs_b[g]),
      .i_SPI_Mosi   (mosi),
      .o_SPI_Miso   (miso[g]),
      .o_SPI_MisoEn (misoen[g])
    );
  end

  assign cur_miso = miso[sel];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=none required=event (t=%0t)", name, $time);
  endtask

  // Rx scoreboard and pulse counters
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && mon_en) begin
        if (underrun[sel]) ur_pulses++;
        if (rx_valid[sel]) begin
          rx_pulses++;
          if (exp_rx.size() == 0) fail_now("rx_unexpected_valid");
          else chk("rx_byte", {24'h0, rx_byte[sel]}, {24'h0, exp_rx.pop_front()});
        end
      end
    end
  end

  // MISO may only move within a few clk of a shift edge (or of the CS fall)
  initial begin
    time t;
    forever begin
      @(cur_miso);
      t = $time;
      #1;
      if (mon_en && !reset && misoen[sel] === 1'b1)
        chk("miso_change_window", 32'((t - last_ok_time) <= 50 && t > last_ok_time), 32'd1);
    end
  end

  task automatic sclk_toggle(input logic [1:0] m, input bit is_shift);
    sclk[m] = ~sclk[m];
    if (is_shift) last_ok_time = $time;
  endtask

  task automatic half_wait();
    repeat (8) @(negedge clk);
  endtask

  // Master: sends word[23:24-nbits] MSB first under one CS, checks each full returned byte.
  task automatic spi_xfer(input logic [23:0] word, input int nbits);
    logic [1:0] m;
    logic [7:0] got;
    m = sel;
    got = 8'h00;
    @(negedge clk);
    cs_b[m] = 1'b0;
    last_ok_time = $time;
    half_wait();
    for (int i = 0; i < nbits; i++) begin
      if (!m[0]) begin
        mosi = word[23-i];
        half_wait();
        sclk_toggle(m, 1'b0);
        got = {got[6:0], miso[m]};
        half_wait();
        sclk_toggle(m, 1'b1);
      end else begin
        sclk_toggle(m, 1'b1);
        mosi = word[23-i];
        half_wait();
        sclk_toggle(m, 1'b0);
        got = {got[6:0], miso[m]};
        half_wait();
      end
      if (i % 8 == 7) begin
        if (exp_miso.size() == 0) fail_now("miso_unexpected_byte");
        else chk("miso_byte", {24'h0, got}, {24'h0, exp_miso.pop_front()});
      end
    end
    half_wait();
    chk("misoen_active", {31'h0, misoen[m]}, 32'd1);
    cs_b[m] = 1'b1;
    half_wait();
  endtask

  task automatic push_tx(input logic [7:0] b);
    logic [1:0] m;
    int n;
    m = sel;
    n = 0;
    @(negedge clk);
    while (!tx_ready[m] && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready[m]) begin
      fail_now("tx_ready_timeout");
    end else begin
      tx_byte = b;
      tx_valid[m] = 1'b1;
      @(negedge clk);
      tx_valid[m] = 1'b0;
      chk("tx_ready_fall", {31'h0, tx_ready[m]}, 32'd0);
    end
  endtask

  task automatic check_reset_vals(input logic [1:0] m);
    chk("rst_tx_ready", {31'h0, tx_ready[m]}, 32'd1);
    chk("rst_rx_byte", {24'h0, rx_byte[m]}, 32'h0);
    chk("rst_rx_valid", {31'h0, rx_valid[m]}, 32'd0);
    chk("rst_underrun", {31'h0, underrun[m]}, 32'd0);
    chk("rst_miso", {31'h0, miso[m]}, 32'd0);
    chk("rst_misoen", {31'h0, misoen[m]}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0, u0;
    reset = 1'b1;
    tx_byte = 8'h00;
    tx_valid = 4'b0000;
    sclk = 4'b1100;
    cs_b = 4'b1111;
    mosi = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_vals(2'd0);
    check_reset_vals(2'd3);
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (4) @(negedge clk);

    // mode 0 single byte
    sel = 2'd0;
    p0 = rx_pulses;
    push_tx(8'hA5);
    exp_rx.push_back(8'h3C);
    exp_miso.push_back(8'hA5);
    spi_xfer(24'h3C0000, 8);
    chk("t1_rx_pulses", 32'(rx_pulses - p0), 32'd1);
    chk("t1_tx_ready_back", {31'h0, tx_ready[0]}, 32'd1);
    chk("t1_rx_drained", 32'(exp_rx.size()), 32'd0);

    // mode 0, three bytes under one CS, Tx fed just in time
    p0 = rx_pulses;
    push_tx(8'h11);
    exp_rx.push_back(8'h01); exp_rx.push_back(8'h02); exp_rx.push_back(8'h03);
    exp_miso.push_back(8'h11); exp_miso.push_back(8'h22); exp_miso.push_back(8'h33);
    fork
      spi_xfer(24'h010203, 24);
      begin
        push_tx(8'h22);
        push_tx(8'h33);
      end
    join
    chk("t2_rx_pulses", 32'(rx_pulses - p0), 32'd3);
    chk("t2_rx_drained", 32'(exp_rx.size()), 32'd0);

    // underrun in mode 1: nothing queued, one byte
    sel = 2'd1;
    u0 = ur_pulses;
    exp_rx.push_back(8'h96);
    exp_miso.push_back(8'hFF);
    spi_xfer(24'h960000, 8);
    chk("t3_underrun_pulses", 32'(ur_pulses - u0), 32'd1);

    // mode 0 partial byte then a full one
    sel = 2'd0;
    p0 = rx_pulses;
    spi_xfer(24'hB80000, 5);
    chk("t4_no_rx_valid", 32'(rx_pulses - p0), 32'd0);
    chk("t4_misoen_low", {31'h0, misoen[0]}, 32'd0);
    exp_rx.push_back(8'hC3);
    exp_miso.push_back(8'hFF);
    spi_xfer(24'hC30000, 8);
    chk("t4_rx_pulses", 32'(rx_pulses - p0), 32'd1);

    // modes 1..3 exchange
    for (int m = 1; m < 4; m++) begin
      sel = 2'(m);
      p0 = rx_pulses;
      push_tx(8'hA5);
      exp_rx.push_back(8'h5A);
      exp_miso.push_back(8'hA5);
      spi_xfer(24'h5A0000, 8);
      chk("t5_rx_pulses", 32'(rx_pulses - p0), 32'd1);
    end

    // reset mid-byte in mode 0 with a Tx byte queued
    sel = 2'd0;
    @(negedge clk);
    cs_b[0] = 1'b0;
    last_ok_time = $time;
    half_wait();
    push_tx(8'h77);
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1;
      half_wait();
      sclk_toggle(2'd0, 1'b0);
      half_wait();
      sclk_toggle(2'd0, 1'b1);
    end
    mosi = 1'b0;
    half_wait();
    sclk_toggle(2'd0, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals(2'd0);
    sclk[0] = 1'b0;
    cs_b[0] = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    p0 = rx_pulses;
    exp_rx.push_back(8'hE7);
    exp_miso.push_back(8'hFF);
    spi_xfer(24'hE70000, 8);
    chk("t6_rx_pulses", 32'(rx_pulses - p0), 32'd1);

    repeat (10) @(negedge clk);
    chk("end_rx_queue_empty", 32'(exp_rx.size()), 32'd0);
    chk("end_miso_queue_empty", 32'(exp_miso.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
